// File: rtl/core_pkg.sv
// core_pkg: shared funct3 encodings, memory FSM states and helpers
// for the memory-access stage.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_DATA = 2'd2
  } mem_state_e;

  function automatic logic f3_is_byte(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic f3_is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: sub-word store lane replication / byte enables
// and load extraction with sign or zero extension.
module mem_lane_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // pick the addressed byte and half out of the returned word
  always_comb begin
    rbyte = rdata[7:0];
    unique case (lane)
      2'd0: rbyte = rdata[7:0];
      2'd1: rbyte = rdata[15:8];
      2'd2: rbyte = rdata[23:16];
      2'd3: rbyte = rdata[31:24];
      default: rbyte = rdata[7:0];
    endcase
    rhalf = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  // size decode; funct3[2] selects zero extension
  always_comb begin
    wdata = sdata;
    wstrb = 4'b1111;
    ldata = rdata;
    unique case (1'b1)
      f3_is_byte(funct3): begin
        wdata = {4{sdata[7:0]}};
        wstrb = 4'b0001 << lane;
        ldata = funct3[2] ? {24'd0, rbyte}
                          : {{24{rbyte[7]}}, rbyte};
      end
      f3_is_half(funct3): begin
        wdata = {2{sdata[15:0]}};
        wstrb = 4'b0011 << {lane[1], 1'b0};
        ldata = funct3[2] ? {16'd0, rhalf}
                          : {{16{rhalf[15]}}, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: req/gnt/rvalid data-memory stage feeding writeback.
// Optional MISALIGN_TRAP_EN: misaligned accesses are flagged, not issued.
module mem_access_stage
  import core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RSEL_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       ac_pc,
  input  logic [RSEL_W-1:0] ac_write_sel,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       ac_data2,
  input  logic [2:0]        ac_funct3,
  input  logic              ac_is_load,
  input  logic              ac_is_store,
  input  logic              ac_is_wb,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic [31:0]       cw_pc,
  output logic [RSEL_W-1:0] cw_write_sel,
  output logic [31:0]       cw_result,
  output logic              cw_is_wb,
  output logic              cw_misalign
);

  mem_state_e state_q, state_d;

  logic        is_acc;
  logic        misalign;
  logic        is_mem;
  logic        req;
  logic        done;
  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic [31:0] al_ldata;

  assign is_acc = ac_is_load | ac_is_store;

`ifdef MISALIGN_TRAP_EN
  assign misalign = is_acc & (
    f3_is_byte(ac_funct3) ? 1'b0 :
    f3_is_half(ac_funct3) ? alu_result[0] :
    (alu_result[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign is_mem = is_acc & ~misalign;

  mem_lane_align u_align (
    .funct3 (ac_funct3),
    .lane   (alu_result[1:0]),
    .sdata  (ac_data2),
    .rdata  (mem_rdata),
    .wdata  (al_wdata),
    .wstrb  (al_wstrb),
    .ldata  (al_ldata)
  );

  // next-state, request and completion decode
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_mem) begin
          req = 1'b1;
          if (!mem_gnt)        state_d = WAIT_GNT;
          else if (ac_is_load) state_d = WAIT_DATA;
          else                 done    = 1'b1;
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (mem_gnt) begin
          if (ac_is_load) begin
            state_d = WAIT_DATA;
          end else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DATA: begin
        if (mem_rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = req & ~reset;
  assign mem_we    = mem_req & ~ac_is_load;
  assign mem_addr  = mem_req ? {alu_result[ADDR_W-1:2], 2'b00}
                             : '0;
  assign mem_wdata = mem_we ? al_wdata : 32'd0;
  assign mem_wstrb = mem_we ? al_wstrb : 4'd0;
  assign mem_stall = ((state_q != IDLE) | is_mem) & ~done & ~reset;

  // state register; reset abandons any access in flight
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // writeback registers advance only when the stage is not stalled
  always_ff @(posedge clock) begin
    if (reset) begin
      cw_pc        <= 32'd0;
      cw_write_sel <= '0;
      cw_result    <= 32'd0;
      cw_is_wb     <= 1'b0;
      cw_misalign  <= 1'b0;
    end else if (!mem_stall) begin
      cw_pc        <= ac_pc;
      cw_write_sel <= ac_write_sel;
      cw_result    <= (ac_is_load & ~misalign) ? al_ldata
                                               : alu_result;
      cw_is_wb     <= ac_is_wb & ~misalign;
      cw_misalign  <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vectors with a writeback scoreboard
// and a decoupled monitor.
module tb_mem_access_stage;
  import core_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ac_pc;
  logic [4:0]  ac_write_sel;
  logic [31:0] alu_result;
  logic [31:0] ac_data2;
  logic [2:0]  ac_funct3;
  logic        ac_is_load;
  logic        ac_is_store;
  logic        ac_is_wb;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic [31:0] cw_pc;
  logic [4:0]  cw_write_sel;
  logic [31:0] cw_result;
  logic        cw_is_wb;
  logic        cw_misalign;

  mem_access_stage #(.ADDR_W(32), .RSEL_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .ac_pc        (ac_pc),
    .ac_write_sel (ac_write_sel),
    .alu_result   (alu_result),
    .ac_data2     (ac_data2),
    .ac_funct3    (ac_funct3),
    .ac_is_load   (ac_is_load),
    .ac_is_store  (ac_is_store),
    .ac_is_wb     (ac_is_wb),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .mem_stall    (mem_stall),
    .cw_pc        (cw_pc),
    .cw_write_sel (cw_write_sel),
    .cw_result    (cw_result),
    .cw_is_wb     (cw_is_wb),
    .cw_misalign  (cw_misalign)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  sel;
    logic [31:0] res;
    logic        wb;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic active = 1'b0;
  logic mon_st;
  logic mon_act;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor: pop and compare on every unstalled cycle of a tracked op
  always @(posedge clock) begin
    mon_st  = mem_stall;
    mon_act = active & ~reset;
    #1;
    if (mon_act && !mon_st) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got empty want entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cw_pc", cw_pc, e.pc);
        chk("cw_sel", {27'd0, cw_write_sel}, {27'd0, e.sel});
        chk("cw_result", cw_result, e.res);
        chk("cw_is_wb", {31'd0, cw_is_wb}, {31'd0, e.wb});
        chk("cw_misalign", {31'd0, cw_misalign}, {31'd0, e.mis});
      end
    end
  end

  task automatic op(
    input string       nm,
    input logic [31:0] pc,
    input logic [4:0]  sel,
    input logic [31:0] alu,
    input logic [31:0] sd,
    input logic [2:0]  f3,
    input logic        ld,
    input logic        st,
    input logic        wb,
    input int          gdly,
    input logic [31:0] rd,
    input logic [31:0] eres,
    input logic        ewb,
    input logic        emis,
    input logic        ereq,
    input int          estall,
    input logic        chka,
    input logic [31:0] eaddr,
    input logic [31:0] ewdata,
    input logic [3:0]  estrb
  );
    int          stalls = 0;
    int          gcnt = 0;
    int          cyc = 0;
    logic        granted = 1'b0;
    logic        rvp = 1'b0;
    logic        seen = 1'b0;
    logic        fin = 1'b0;
    logic [31:0] c_addr = 32'd0;
    logic [31:0] c_wdata = 32'd0;
    logic [3:0]  c_strb = 4'd0;
    exp_t        e;
    e.pc = pc; e.sel = sel; e.res = eres; e.wb = ewb; e.mis = emis;
    exp_q.push_back(e);
    @(negedge clock);
    ac_pc = pc; ac_write_sel = sel; alu_result = alu;
    ac_data2 = sd; ac_funct3 = f3;
    ac_is_load = ld; ac_is_store = st; ac_is_wb = wb;
    active = 1'b1;
    while (!fin && cyc < 30) begin
      mem_gnt = 1'b0;
      mem_rvalid = rvp;
      mem_rdata = rvp ? rd : 32'd0;
      #1;
      if (mem_req && !granted) begin
        if (!seen) begin
          c_addr = mem_addr; c_wdata = mem_wdata; c_strb = mem_wstrb;
        end
        seen = 1'b1;
        if (gcnt == gdly) mem_gnt = 1'b1;
        gcnt++;
      end
      #1;
      if (mem_stall) stalls++;
      else fin = 1'b1;
      @(posedge clock);
      if (mem_gnt) begin
        granted = 1'b1;
        rvp = ld;
      end
      cyc++;
      if (!fin) @(negedge clock);
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got stuck want completion", nm);
    end
    chk({nm, "_req"}, {31'd0, seen}, {31'd0, ereq});
    chk({nm, "_stalls"}, stalls, estall);
    if (chka) begin
      chk({nm, "_addr"}, c_addr, eaddr);
      if (st) begin
        chk({nm, "_wdata"}, c_wdata, ewdata);
        chk({nm, "_wstrb"}, {28'd0, c_strb}, {28'd0, estrb});
      end
    end
    @(negedge clock);
    active = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    ac_is_load = 1'b0; ac_is_store = 1'b0; ac_is_wb = 1'b0;
    alu_result = 32'd0; ac_pc = 32'd0; ac_data2 = 32'd0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req"}, {31'd0, mem_req}, 32'd0);
    chk({nm, "_stall"}, {31'd0, mem_stall}, 32'd0);
    chk({nm, "_addr"}, mem_addr, 32'd0);
    chk({nm, "_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    chk({nm, "_cw_pc"}, cw_pc, 32'd0);
    chk({nm, "_cw_result"}, cw_result, 32'd0);
    chk({nm, "_cw_is_wb"}, {31'd0, cw_is_wb}, 32'd0);
    chk({nm, "_cw_mis"}, {31'd0, cw_misalign}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    ac_pc = 32'd0; ac_write_sel = 5'd0; alu_result = 32'd0;
    ac_data2 = 32'd0; ac_funct3 = 3'd0;
    ac_is_load = 1'b0; ac_is_store = 1'b0; ac_is_wb = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    chk_zero("rst");
    @(negedge clock);
    reset = 1'b0;

    op("alu", 32'h10, 5'd1, 32'h1234, 32'd0, F3_W, 0, 0, 1,
       0, 32'd0, 32'h1234, 1, 0, 0, 0, 0, 0, 0, 4'd0);
    op("sb", 32'h14, 5'd0, 32'h103, 32'hAB, F3_B, 0, 1, 0,
       0, 32'd0, 32'h103, 0, 0, 1, 0,
       1, 32'h100, 32'hABABABAB, 4'b1000);
    op("lb", 32'h18, 5'd5, 32'h102, 32'd0, F3_B, 1, 0, 1,
       2, 32'h00800000, 32'hFFFFFF80, 1, 0, 1, 3,
       1, 32'h100, 32'd0, 4'd0);
    op("lbu", 32'h1C, 5'd6, 32'h102, 32'd0, F3_BU, 1, 0, 1,
       2, 32'h00800000, 32'h00000080, 1, 0, 1, 3,
       0, 0, 0, 4'd0);
    op("lh", 32'h20, 5'd7, 32'h102, 32'd0, F3_H, 1, 0, 1,
       0, 32'h8001FFFF, 32'hFFFF8001, 1, 0, 1, 1,
       0, 0, 0, 4'd0);
    op("lhu", 32'h24, 5'd8, 32'h102, 32'd0, F3_HU, 1, 0, 1,
       0, 32'h8001FFFF, 32'h00008001, 1, 0, 1, 1,
       0, 0, 0, 4'd0);
    op("sh", 32'h28, 5'd0, 32'h102, 32'h12345678, F3_H, 0, 1, 0,
       1, 32'd0, 32'h102, 0, 0, 1, 1,
       1, 32'h100, 32'h56785678, 4'b1100);
    op("sw", 32'h2C, 5'd0, 32'h200, 32'hDEADBEEF, F3_W, 0, 1, 0,
       0, 32'd0, 32'h200, 0, 0, 1, 0,
       1, 32'h200, 32'hDEADBEEF, 4'b1111);
`ifdef MISALIGN_TRAP_EN
    op("lw_mis", 32'h30, 5'd9, 32'h101, 32'd0, F3_W, 1, 0, 1,
       0, 32'h11223344, 32'h101, 0, 1, 0, 0,
       0, 0, 0, 4'd0);
`else
    op("lw_mis", 32'h30, 5'd9, 32'h101, 32'd0, F3_W, 1, 0, 1,
       0, 32'h11223344, 32'h11223344, 1, 0, 1, 1,
       1, 32'h100, 32'd0, 4'd0);
`endif

    // abandon a load in WAIT_DATA with reset, then pulse a late rvalid
    @(negedge clock);
    ac_pc = 32'h40; ac_write_sel = 5'd3; alu_result = 32'h104;
    ac_funct3 = F3_W; ac_is_load = 1'b1; ac_is_wb = 1'b1;
    #1;
    chk("abort_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = mem_req;
    @(posedge clock);
    @(negedge clock);
    mem_gnt = 1'b0;
    #1;
    chk("abort_wait_stall", {31'd0, mem_stall}, 32'd1);
    reset = 1'b1;
    ac_is_load = 1'b0; ac_is_wb = 1'b0;
    alu_result = 32'd0; ac_pc = 32'd0; ac_write_sel = 5'd0;
    @(posedge clock);
    #1;
    chk_zero("abort_rst");
    @(negedge clock);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1;
    chk("late_rv_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clock);
    #1;
    chk("late_rv_result", cw_result, 32'd0);
    chk("late_rv_wb", {31'd0, cw_is_wb}, 32'd0);
    @(negedge clock);
    mem_rvalid = 1'b0; mem_rdata = 32'd0;

    op("alu2", 32'h44, 5'd2, 32'h55, 32'd0, F3_W, 0, 0, 1,
       0, 32'd0, 32'h55, 1, 0, 0, 0, 0, 0, 0, 4'd0);

    repeat (3) @(posedge clock);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage sitting between execute and writeback. It issues loads and stores to an external data-memory port with a request/grant/response handshake, so it tolerates variable-latency memories. It performs RISC-V sub-word byte, halfword and word alignment with sign or zero extension, and stalls the upstream pipeline until the access completes. Its registered outputs feed writeback.

## Interface
Parameters:
- ADDR_W, 32, width of the memory address (low ADDR_W bits of alu_result)
- RSEL_W, 5, register-select width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- ac_pc  in  32  PC of instruction in stage
- ac_write_sel  in  RSEL_W  destination register
- alu_result  in  32  effective address (load/store) or result (others)
- ac_data2  in  32  store data
- ac_funct3  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- ac_is_load, ac_is_store, ac_is_wb  in  1 each  instruction class
- mem_req  out  1  access request
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load word
- mem_stall  out  1  hold upstream ac_* stable
- cw_pc, cw_write_sel, cw_result, cw_is_wb  out  32/RSEL_W/32/1  writeback registers
- cw_misalign  out  1  misaligned-access flag

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_DATA. Reset -> IDLE.
- IDLE:
  - Non-memory instruction: pass-through, no stall. cw_result <= alu_result.
  - Load/store: mem_req asserted combinationally.
    - Store with gnt: completes this cycle.
    - Store without gnt: go to WAIT_GNT.
    - Load with gnt: go to WAIT_DATA.
    - Load without gnt: go to WAIT_GNT.
- WAIT_GNT:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are held.
  - On gnt: a store completes and returns to IDLE; a load goes to WAIT_DATA.
- WAIT_DATA:
  - mem_req is low.
  - On rvalid: the load completes and the FSM returns to IDLE.
- mem_stall = memory access present AND not completing this cycle. Outputs cw_* update only on cycles where mem_stall is 0.
- Protocol: rvalid arrives at least 1 cycle after gnt. rvalid in IDLE or WAIT_GNT is ignored.
- Store alignment, where lane = addr[1:0]:
  - sb: wdata = byte replicated ×4, wstrb = 0001 << lane.
  - sh: wdata = half replicated ×2, wstrb = 0011 << (2·addr[1]).
  - sw: wstrb = 1111.
- Load extraction: select the byte or half by addr bits, then sign-extend (lb, lh) or zero-extend (lbu, lhu). lw passes the word through.
- Unlisted funct3 codes are treated as word.
- cw_result on a load = extracted data. cw_result on a store = alu_result. cw_is_wb = ac_is_wb.

## Timing
- Reset value of every output is 0 (cw_*, cw_misalign, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_stall). Reset also forces state to IDLE.
- Non-memory instruction: 1 cycle.
- Store with zero-wait gnt: 1 cycle. Load with zero-wait gnt and rvalid the next cycle: 2 cycles (1 stall).
- Each extra gnt or rvalid wait adds exactly one stall cycle.
- Reset mid-access (WAIT_GNT or WAIT_DATA): the access is abandoned, mem_req drops the next cycle, and a late rvalid is ignored.
- No new request is issued in the completion cycle.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned accesses are detected: half with addr[0]=1, word with addr[1:0]≠0.
  - They are not issued (mem_req stays 0) and complete in 1 cycle.
  - Result: cw_misalign=1, cw_is_wb=0, cw_result=alu_result.
- MISALIGN_TRAP_EN undefined:
  - No check is made. A word access uses the aligned-down address. A half access uses addr[1] only.
  - cw_misalign is tied to 0.

## Structure
- Shared package core_pkg: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state enum.
- One combinational sub-module, mem_lane_align: takes funct3, addr[1:0] and store data, and produces wdata, wstrb and the extracted load result.

## Test plan
- Non-memory instruction: alu_result=0x1234, ac_is_wb=1 -> next edge cw_result=0x1234, mem_req never 1, mem_stall=0.
- sb at addr 0x103, data 0xAB, zero-wait gnt -> mem_addr=0x100, wstrb=1000, wdata=0xABABABAB, stall 0.
- lb at addr 0x102, gnt delayed 2 cycles, rdata=0x00800000 one cycle after gnt:
  - 3 stall cycles, then cw_result=0xFFFFFF80.
  - Repeat as lbu: cw_result=0x00000080.
- lh at 0x102, rdata=0x8001FFFF -> cw_result=0xFFFF8001. lhu -> 0x00008001.
- Reset asserted in WAIT_DATA, then rvalid pulsed -> all outputs 0, state IDLE, rvalid ignored.
- lw at 0x101:
  - With MISALIGN_TRAP_EN: no mem_req, cw_misalign=1, cw_is_wb=0.
  - Without it: mem_addr=0x100, cw_misalign=0.
